// File: rtl/tlut_pkg.sv
// Shared constants and types for the TLUT stream controller.
// Dimensions here are the defaults used by tlut_stream_ctrl and its drain sub-module.
package tlut_pkg;

  localparam int DIM_ROW1     = 3;
  localparam int DIM_COL1     = 3;
  localparam int DIM_COL2     = 3;
  localparam int INPUT_WIDTH  = 4;
  localparam int WEIGHT_WIDTH = 4;
  localparam int ACC_WIDTH    = 13;
  localparam int CELL_LATENCY = 4;

  localparam int N_A = DIM_ROW1 * DIM_COL1;
  localparam int N_B = DIM_COL1 * DIM_COL2;
  localparam int N_P = DIM_ROW1 * DIM_COL2;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD_A  = 3'd1,
    LOAD_B  = 3'd2,
    COMPUTE = 3'd3,
    DRAIN   = 3'd4
  } tlut_ctrl_state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/tlut_result_drain.sv
// Result buffer and output stream for the TLUT controller.
// Captures the cell product vector once, then hands elements out in order
// over valid/ready, flagging the final element with out_last.
module tlut_result_drain
  import tlut_pkg::*;
#(
  parameter int N_ELEM = tlut_pkg::N_P,
  parameter int ACC_W  = tlut_pkg::ACC_WIDTH,
  parameter int CNT_W  = 5
)(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    capture,
  input  logic                    active,
  input  logic [N_ELEM*ACC_W-1:0] cell_result,
  input  logic                    out_ready,
  output logic                    out_valid,
  output logic [ACC_W-1:0]        out_data,
  output logic                    out_last,
  output logic                    done
);

  localparam int               P_IW   = (N_ELEM > 1) ? $clog2(N_ELEM) : 1;
  localparam logic [CNT_W-1:0] P_LAST = CNT_W'(N_ELEM - 1);

  logic [N_ELEM-1:0][ACC_W-1:0] res_buf;
  logic [CNT_W-1:0]             idx;
  logic                         is_last;
  logic                         xfer;

  assign is_last   = (idx == P_LAST);
  assign xfer      = active & out_ready;
  assign out_valid = active;
  assign out_last  = active & is_last;
  assign out_data  = active ? res_buf[P_IW'(idx)] : '0;
  assign done      = xfer & is_last;

  // Snapshot the whole product vector on the final compute cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      res_buf <= '0;
    end else if (capture) begin
      res_buf <= cell_result;
    end
  end

  // Element index advances only on an accepted handshake, so data holds under stall
  always_ff @(posedge clk) begin
    if (rst) begin
      idx <= '0;
    end else if (xfer) begin
      idx <= is_last ? '0 : idx + 1'b1;
    end
  end

endmodule

// File: rtl/tlut_stream_ctrl.sv
// Host-side sequencer for the TLUT matrix cell (simd_cell).
// Streams A then B in row-major order, holds cell_enable for CELL_LATENCY
// cycles, captures the product and streams it back out.
// Optional build macro: TLUT_OP_COUNT_EN enables the saturating op_count register.
module tlut_stream_ctrl
  import tlut_pkg::*;
#(
  parameter int DIM_ROW1     = tlut_pkg::DIM_ROW1,
  parameter int DIM_COL1     = tlut_pkg::DIM_COL1,
  parameter int DIM_COL2     = tlut_pkg::DIM_COL2,
  parameter int INPUT_WIDTH  = tlut_pkg::INPUT_WIDTH,
  parameter int WEIGHT_WIDTH = tlut_pkg::WEIGHT_WIDTH,
  parameter int ACC_WIDTH    = tlut_pkg::ACC_WIDTH,
  parameter int CELL_LATENCY = tlut_pkg::CELL_LATENCY
)(
  input  logic                                                          clk,
  input  logic                                                          rst,
  input  logic                                                          in_valid,
  output logic                                                          in_ready,
  input  logic [((INPUT_WIDTH > WEIGHT_WIDTH) ? INPUT_WIDTH : WEIGHT_WIDTH)-1:0] in_data,
  output logic                                                          out_valid,
  input  logic                                                          out_ready,
  output logic [ACC_WIDTH-1:0]                                          out_data,
  output logic                                                          out_last,
  output logic                                                          busy,
  output logic                                                          cell_enable,
  output logic [DIM_ROW1*DIM_COL1*INPUT_WIDTH-1:0]                      cell_input_bin,
  output logic [DIM_COL1*DIM_COL2*WEIGHT_WIDTH-1:0]                     cell_weight_bin,
  input  logic [DIM_ROW1*DIM_COL2*ACC_WIDTH-1:0]                        cell_result,
  output logic [15:0]                                                   op_count
);

  localparam int NA    = DIM_ROW1 * DIM_COL1;
  localparam int NB    = DIM_COL1 * DIM_COL2;
  localparam int NP    = DIM_ROW1 * DIM_COL2;
  localparam int CNT_W = $clog2(max_int(max_int(NA, NB), max_int(NP, CELL_LATENCY))) + 1;
  localparam int A_IW  = (NA > 1) ? $clog2(NA) : 1;
  localparam int B_IW  = (NB > 1) ? $clog2(NB) : 1;

  localparam logic [CNT_W-1:0] A_LAST      = CNT_W'(NA - 1);
  localparam logic [CNT_W-1:0] B_LAST      = CNT_W'(NB - 1);
  localparam logic [CNT_W-1:0] T_LAST      = CNT_W'(CELL_LATENCY - 1);
  localparam logic [CNT_W-1:0] IDX_AFTER_0 = (NA == 1) ? CNT_W'(0) : CNT_W'(1);

  tlut_ctrl_state_t state, state_nxt;

  logic [CNT_W-1:0]                    load_idx;
  logic [CNT_W-1:0]                    timer;
  logic [NA-1:0][INPUT_WIDTH-1:0]      a_reg;
  logic [NB-1:0][WEIGHT_WIDTH-1:0]     b_reg;
  logic                                beat;
  logic                                capture;
  logic                                drain_active;
  logic                                drain_done;

  assign beat            = in_valid & in_ready;
  assign capture         = (state == COMPUTE) && (timer == T_LAST);
  assign cell_input_bin  = a_reg;
  assign cell_weight_bin = b_reg;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state: load A, load B, fixed compute window, drain until last element taken
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (beat) state_nxt = (NA == 1) ? LOAD_B : LOAD_A;
      LOAD_A:  if (beat && load_idx == A_LAST) state_nxt = LOAD_B;
      LOAD_B:  if (beat && load_idx == B_LAST) state_nxt = COMPUTE;
      COMPUTE: if (capture) state_nxt = DRAIN;
      DRAIN:   if (drain_done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs decoded from state; reset masks the handshakes so nothing is taken or offered
  always_comb begin
    in_ready     = 1'b0;
    busy         = 1'b1;
    cell_enable  = 1'b0;
    drain_active = 1'b0;
    case (state)
      IDLE: begin
        in_ready = !rst;
        busy     = 1'b0;
      end
      LOAD_A, LOAD_B: in_ready = !rst;
      COMPUTE:        cell_enable = 1'b1;
      DRAIN:          drain_active = !rst;
      default:        ;
    endcase
  end

  // Load element index and compute-window timer
  always_ff @(posedge clk) begin
    if (rst) begin
      load_idx <= '0;
      timer    <= '0;
    end else begin
      case (state)
        IDLE:    if (beat) load_idx <= IDX_AFTER_0;
        LOAD_A:  if (beat) load_idx <= (load_idx == A_LAST) ? '0 : load_idx + 1'b1;
        LOAD_B:  if (beat) load_idx <= (load_idx == B_LAST) ? '0 : load_idx + 1'b1;
        default: load_idx <= '0;
      endcase
      timer <= (state == COMPUTE && !capture) ? timer + 1'b1 : '0;
    end
  end

  // Operand registers; only the low element-width bits of each beat are kept
  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg <= '0;
      b_reg <= '0;
    end else if (beat) begin
      case (state)
        IDLE:    a_reg[A_IW'(0)]        <= in_data[INPUT_WIDTH-1:0];
        LOAD_A:  a_reg[A_IW'(load_idx)] <= in_data[INPUT_WIDTH-1:0];
        LOAD_B:  b_reg[B_IW'(load_idx)] <= in_data[WEIGHT_WIDTH-1:0];
        default: ;
      endcase
    end
  end

  tlut_result_drain #(
    .N_ELEM (NP),
    .ACC_W  (ACC_WIDTH),
    .CNT_W  (CNT_W)
  ) u_drain (
    .clk         (clk),
    .rst         (rst),
    .capture     (capture),
    .active      (drain_active),
    .cell_result (cell_result),
    .out_ready   (out_ready),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_last    (out_last),
    .done        (drain_done)
  );

`ifdef TLUT_OP_COUNT_EN
  logic [15:0] op_cnt_q;

  // Completed-operation counter, saturating at all-ones
  always_ff @(posedge clk) begin
    if (rst) begin
      op_cnt_q <= '0;
    end else if (drain_done && op_cnt_q != 16'hFFFF) begin
      op_cnt_q <= op_cnt_q + 16'd1;
    end
  end

  assign op_count = op_cnt_q;
`else
  assign op_count = '0;
`endif

endmodule

// File: tb/tb_tlut_stream_ctrl.sv
// Self-checking bench for tlut_stream_ctrl with a behavioural simd_cell stand-in.
module tb_tlut_stream_ctrl;

  localparam int R1  = tlut_pkg::DIM_ROW1;
  localparam int C1  = tlut_pkg::DIM_COL1;
  localparam int C2  = tlut_pkg::DIM_COL2;
  localparam int IW  = tlut_pkg::INPUT_WIDTH;
  localparam int WW  = tlut_pkg::WEIGHT_WIDTH;
  localparam int AW  = tlut_pkg::ACC_WIDTH;
  localparam int LAT = tlut_pkg::CELL_LATENCY;
  localparam int NA  = R1 * C1;
  localparam int NB  = C1 * C2;
  localparam int NP  = R1 * C2;
  localparam int DW  = (IW > WW) ? IW : WW;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [DW-1:0]     in_data;
  logic              out_valid;
  logic              out_ready;
  logic [AW-1:0]     out_data;
  logic              out_last;
  logic              busy;
  logic              cell_enable;
  logic [NA*IW-1:0]  cell_input_bin;
  logic [NB*WW-1:0]  cell_weight_bin;
  logic [NP*AW-1:0]  cell_result;
  logic [15:0]       op_count;

  int tests = 0;
  int fails = 0;
  int ma[NA];
  int mb[NB];
  int exp_p[NP];
  int ops_since_reset = 0;

  int   cyc = 0;
  int   acc_cyc = 0;
  int   ov_cyc = 0;
  int   en_cyc = 0;
  logic ov_prev = 1'b0;
  logic [AW-1:0] got_data[$];
  bit            got_last[$];

  always #5 clk = ~clk;

  tlut_stream_ctrl dut (
    .clk             (clk),
    .rst             (rst),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_data         (in_data),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_data        (out_data),
    .out_last        (out_last),
    .busy            (busy),
    .cell_enable     (cell_enable),
    .cell_input_bin  (cell_input_bin),
    .cell_weight_bin (cell_weight_bin),
    .cell_result     (cell_result),
    .op_count        (op_count)
  );

  // simd_cell stand-in: product of the presented operands, valid only while enabled
  always @(posedge clk) begin : cell_model
    int s;
    if (cell_enable === 1'b1) begin
      for (int i = 0; i < R1; i++) begin
        for (int j = 0; j < C2; j++) begin
          s = 0;
          for (int k = 0; k < C1; k++)
            s += int'(cell_input_bin[(i*C1+k)*IW +: IW]) * int'(cell_weight_bin[(k*C2+j)*WW +: WW]);
          cell_result[(i*C2+j)*AW +: AW] <= AW'(s);
        end
      end
    end else begin
      cell_result <= '0;
    end
  end

  // Observer: handshake log, operation start, first out_valid, enable cycles
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (in_valid === 1'b1 && in_ready === 1'b1 && busy === 1'b0) acc_cyc <= cyc;
    if (out_valid === 1'b1 && ov_prev !== 1'b1) ov_cyc <= cyc;
    ov_prev <= out_valid;
    if (cell_enable === 1'b1) en_cyc <= en_cyc + 1;
    if (out_valid === 1'b1 && out_ready === 1'b1) begin
      got_data.push_back(out_data);
      got_last.push_back(out_last);
    end
  end

  function automatic logic [DW-1:0] elem(input int k);
    return (k < NA) ? DW'(ma[k]) : DW'(mb[k - NA]);
  endfunction

  function automatic void set_expected();
    int s;
    for (int i = 0; i < R1; i++)
      for (int j = 0; j < C2; j++) begin
        s = 0;
        for (int k = 0; k < C1; k++) s += ma[i*C1+k] * mb[k*C2+j];
        exp_p[i*C2+j] = s;
      end
  endfunction

  function automatic int exp_op_count();
`ifdef TLUT_OP_COUNT_EN
    return (ops_since_reset > 65535) ? 65535 : ops_since_reset;
`else
    return 0;
`endif
  endfunction

  task automatic send_stream(input int n, input bit bubbles);
    int k = 0;
    int t = 0;
    bit gap = 1'b0;
    while (k < n && t < 400) begin
      @(negedge clk);
      t++;
      if (gap) begin
        in_valid = 1'b0;
        in_data  = DW'($urandom);
        gap      = 1'b0;
      end else begin
        in_valid = 1'b1;
        in_data  = elem(k);
        if (in_ready === 1'b1) begin
          k++;
          gap = bubbles;
        end
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    if (k < n) begin
      tests++;
      fails++;
      $display("FAIL send_timeout: accepted %0d beats, required %0d", k, n);
    end
  endtask

  task automatic drain(input string name, input int base, input int stall_at, input int stall_len, input bit junk);
    int t = 0;
    int stalled = 0;
    logic [AW-1:0] held = '0;
    logic held_last = 1'b0;
    out_ready = 1'b1;
    while (got_data.size() < base + NP && t < 200) begin
      @(negedge clk);
      t++;
      in_valid = junk && !(out_valid === 1'b1 && out_last === 1'b1);
      if (junk) in_data = DW'($urandom);
      if (out_valid === 1'b1 && (got_data.size() - base) == stall_at && stalled < stall_len) begin
        if (stalled == 0) begin
          held      = out_data;
          held_last = out_last;
        end else begin
          tests++;
          if (out_data !== held || out_last !== held_last) begin
            fails++;
            $display("FAIL %s stall_hold: data %0d last %0b, required %0d last %0b",
                     name, out_data, out_last, held, held_last);
          end
        end
        out_ready = 1'b0;
        stalled++;
      end else begin
        out_ready = 1'b1;
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tests++;
    if (got_data.size() < base + NP) begin
      fails++;
      $display("FAIL %s drain_timeout: got %0d elements, required %0d", name, got_data.size() - base, NP);
    end
    @(negedge clk);
    tests++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      fails++;
      $display("FAIL %s idle_after: busy %0b out_valid %0b, required 0 0", name, busy, out_valid);
    end
  endtask

  task automatic check_op(input string name, input int base);
    for (int i = 0; i < NP; i++) begin
      tests++;
      if (base + i >= got_data.size()) begin
        fails++;
        $display("FAIL %s[%0d] missing: no element, required %0d", name, i, exp_p[i]);
      end else begin
        if (got_data[base+i] !== AW'(exp_p[i])) begin
          fails++;
          $display("FAIL %s[%0d] data: got %0d, required %0d", name, i, got_data[base+i], exp_p[i]);
        end
        tests++;
        if (got_last[base+i] !== (i == NP - 1)) begin
          fails++;
          $display("FAIL %s[%0d] last: got %0b, required %0b", name, i, got_last[base+i], (i == NP - 1));
        end
      end
    end
    tests++;
    if (got_data.size() != base + NP) begin
      fails++;
      $display("FAIL %s count: got %0d elements, required %0d", name, got_data.size() - base, NP);
    end
  endtask

  task automatic run_op(input string name, input bit bubbles, input int stall_at, input int stall_len, input bit junk);
    int base;
    int e0;
    base = got_data.size();
    e0   = en_cyc;
    send_stream(NA + NB, bubbles);
    drain(name, base, stall_at, stall_len, junk);
    ops_since_reset++;
    check_op(name, base);
    tests++;
    if (en_cyc - e0 != LAT) begin
      fails++;
      $display("FAIL %s enable_cycles: got %0d, required %0d", name, en_cyc - e0, LAT);
    end
    tests++;
    if (op_count !== 16'(exp_op_count())) begin
      fails++;
      $display("FAIL %s op_count: got %0d, required %0d", name, op_count, exp_op_count());
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst      = 1'b1;
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    ops_since_reset = 0;
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    tests++;
    if (in_ready !== 1'b0) begin
      fails++;
      $display("FAIL reset in_ready: got %0b, required 0", in_ready);
    end
    tests++;
    if (out_valid !== 1'b0 || out_last !== 1'b0 || out_data !== '0) begin
      fails++;
      $display("FAIL reset out: valid %0b last %0b data %0d, required 0 0 0", out_valid, out_last, out_data);
    end
    tests++;
    if (busy !== 1'b0 || cell_enable !== 1'b0 || op_count !== 16'd0) begin
      fails++;
      $display("FAIL reset ctrl: busy %0b enable %0b op_count %0d, required 0 0 0", busy, cell_enable, op_count);
    end
    rst = 1'b0;
    ops_since_reset = 0;
    #1;
    tests++;
    if (in_ready !== 1'b1) begin
      fail_line("reset_release in_ready", in_ready, 1);
    end
  endtask

  task automatic fail_line(input string name, input int got, input int req);
    fails++;
    $display("FAIL %s: got %0d, required %0d", name, got, req);
  endtask

  task automatic test_counting();
    int tbl[NP] = '{15, 18, 21, 42, 54, 66, 69, 90, 111};
    for (int i = 0; i < NA; i++) ma[i] = i;
    for (int i = 0; i < NB; i++) mb[i] = i;
    exp_p = tbl;
    run_op("counting", 1'b0, -1, 0, 1'b0);
    tests++;
    if (ov_cyc - acc_cyc != NA + NB + LAT)
      fail_line("counting latency", ov_cyc - acc_cyc, NA + NB + LAT);
  endtask

  task automatic test_uniform();
    for (int i = 0; i < NA; i++) ma[i] = 4;
    for (int i = 0; i < NB; i++) mb[i] = 1;
    for (int i = 0; i < NP; i++) exp_p[i] = 12;
    run_op("uniform", 1'b0, -1, 0, 1'b0);
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < NA; i++) ma[i] = i;
    for (int i = 0; i < NB; i++) mb[i] = i;
    set_expected();
    run_op("backpressure", 1'b1, 4, 3, 1'b0);
  endtask

  task automatic test_max_values();
    for (int i = 0; i < NA; i++) ma[i] = 15;
    for (int i = 0; i < NB; i++) mb[i] = 15;
    for (int i = 0; i < NP; i++) exp_p[i] = 675;
    run_op("max_values", 1'b0, -1, 0, 1'b0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 3; n++) begin
      for (int i = 0; i < NA; i++) ma[i] = int'($urandom_range(0, 15));
      for (int i = 0; i < NB; i++) mb[i] = int'($urandom_range(0, 15));
      set_expected();
      run_op("random", 1'($urandom_range(0, 1)), int'($urandom_range(0, NP - 1)),
             int'($urandom_range(1, 4)), 1'b0);
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < NA; i++) ma[i] = int'($urandom_range(0, 15));
    for (int i = 0; i < NB; i++) mb[i] = int'($urandom_range(0, 15));
    send_stream(5, 1'b0);
    @(negedge clk);
    rst      = 1'b1;
    in_valid = 1'b1;
    in_data  = DW'($urandom);
    #1;
    tests++;
    if (in_ready !== 1'b0) fail_line("reset_mid in_ready", in_ready, 0);
    @(negedge clk);
    tests++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b0)
      fail_line("reset_mid idle", {busy, out_valid, in_ready}, 0);
    rst      = 1'b0;
    in_valid = 1'b0;
    ops_since_reset = 0;
    for (int i = 0; i < NA; i++) ma[i] = 4;
    for (int i = 0; i < NB; i++) mb[i] = 1;
    for (int i = 0; i < NP; i++) exp_p[i] = 12;
    run_op("reset_mid", 1'b0, -1, 0, 1'b0);
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int n = 0; n < 3; n++) begin
      for (int i = 0; i < NA; i++) ma[i] = int'($urandom_range(0, 15));
      for (int i = 0; i < NB; i++) mb[i] = int'($urandom_range(0, 15));
      set_expected();
      run_op("back_to_back", 1'($urandom_range(0, 1)), -1, 0, 1'b1);
    end
    tests++;
`ifdef TLUT_OP_COUNT_EN
    if (op_count !== 16'd3) fail_line("back_to_back final op_count", op_count, 3);
`else
    if (op_count !== 16'd0) fail_line("back_to_back final op_count", op_count, 0);
`endif
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_counting();
    test_uniform();
    test_backpressure();
    test_max_values();
    test_random();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/tlut_stream_ctrl.md
Name: tlut_stream_ctrl

Overview:
- Host-side sequencer for the TLUT matrix cell (`simd_cell`).
- Accepts a serial stream of operand elements over a valid/ready handshake and assembles the packed `input_bin`/`weight_bin` vectors.
- Drives the cell's enable for a fixed compute window, captures `accumulated_mult`, and streams the product elements back out with valid/ready and a last flag.
- Sits between the system bus/DMA and `simd_cell`.

Parameters:
- DIM_ROW1, 3, rows of input matrix A
- DIM_COL1, 3, columns of A = rows of weight matrix B
- DIM_COL2, 3, columns of B
- INPUT_WIDTH, 4, bits per A element
- WEIGHT_WIDTH, 4, bits per B element
- ACC_WIDTH, 13, bits per product element
- CELL_LATENCY, 4, cycles `cell_enable` is held before capture (≥1)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  operand element valid
- in_ready  out  1  controller can accept element
- in_data  in  max(INPUT_WIDTH,WEIGHT_WIDTH)  operand element, LSB-aligned
- out_valid  out  1  product element valid
- out_ready  in  1  sink accepts element
- out_data  out  ACC_WIDTH  product element
- out_last  out  1  final product element of matrix
- busy  out  1  not in IDLE
- cell_enable  out  1  to simd_cell enable
- cell_input_bin  out  DIM_ROW1*DIM_COL1*INPUT_WIDTH  packed A, element k at slice [k]
- cell_weight_bin  out  DIM_COL1*DIM_COL2*WEIGHT_WIDTH  packed B, element k at slice [k]
- cell_result  in  DIM_ROW1*DIM_COL2*ACC_WIDTH  from simd_cell accumulated_mult
- op_count  out  16  completed-operation count (see Optional Feature)

Behaviour:
- Constants: N_A = DIM_ROW1*DIM_COL1, N_B = DIM_COL1*DIM_COL2, N_P = DIM_ROW1*DIM_COL2.
- FSM states: IDLE, LOAD_A, LOAD_B, COMPUTE, DRAIN.
- Reset (clk edge with rst=1) values:
  - state=IDLE; all element counters 0; operand and result registers 0.
  - in_ready=0, out_valid=0, out_last=0, out_data=0, busy=0, cell_enable=0, op_count=0.
- IDLE:
  - in_ready=1.
  - First accepted beat (in_valid&in_ready) writes A[0] and moves to LOAD_A with idx=1.
  - If N_A==1, it moves directly to LOAD_B.
- LOAD_A:
  - in_ready=1. Beat k writes A[k] from in_data[INPUT_WIDTH-1:0]; upper bits are ignored.
  - After beat N_A-1, go to LOAD_B with idx=0.
- LOAD_B:
  - in_ready=1. Beat k writes B[k] from in_data[WEIGHT_WIDTH-1:0].
  - After beat N_B-1, go to COMPUTE with timer=0.
- Element order is row-major for both matrices.
- in_valid low inserts bubbles; the counter holds and the state holds.
- COMPUTE:
  - in_ready=0, cell_enable=1 for exactly CELL_LATENCY cycles.
  - On the last cycle, cell_result is registered into the result buffer.
  - Next state is DRAIN; cell_enable returns to 0.
- cell_input_bin/cell_weight_bin are driven directly from the operand registers and are stable throughout COMPUTE.
- DRAIN:
  - out_valid=1, out_data=P[idx], out_last=(idx==N_P-1).
  - idx advances only on out_valid&out_ready.
  - While out_ready=0, out_data and out_last hold stable.
  - Accepting the last element returns to IDLE on the next cycle; out_valid=0 that cycle; op_count increments.
- in_ready is 0 in COMPUTE and DRAIN; in_valid there is ignored and no data is lost because no handshake occurs.
- busy=1 in every state except IDLE.
- Reset asserted mid-operation: state returns to IDLE next edge; partial operands and undrained results are discarded; no out_valid pulse.
- Arithmetic: the controller performs none. Results pass through unmodified at ACC_WIDTH.
- Counters are sized $clog2(max(N_A,N_B,N_P,CELL_LATENCY))+1 bits.
- Throughput: N_A+N_B+CELL_LATENCY+N_P cycles minimum per operation.

Optional Feature:
- Macro TLUT_OP_COUNT_EN.
- Defined:
  - op_count is a 16-bit register incremented on each completed DRAIN.
  - It saturates at 16'hFFFF and does not wrap.
  - It is cleared only by rst.
- Undefined: op_count tied to 0; no counter flops.

Decomposition:
- Shared package `tlut_pkg` holds:
  - dimension and width constants (DIM_*, *_WIDTH, ACC_WIDTH);
  - derived N_A/N_B/N_P;
  - state enum type `tlut_ctrl_state_t`.
- One natural sub-module, `tlut_result_drain`: result buffer plus output handshake, index counter and out_last generation.
- Load path and FSM stay in the top.

Test Plan:
- The bench instantiates `simd_cell` or a behavioural A×B reference model.
- Test 1, counting matrices: A=0..8, B=0..8, streamed contiguously, out_ready=1.
  - Required: product sequence 15,18,21,42,54,66,69,90,111.
  - out_last is on the 9th beat only.
  - First out_valid occurs exactly 18+CELL_LATENCY cycles after the first accepted beat.
- Test 2, uniform operands: all A=4, all B=1.
  - Required: nine outputs of 12, then busy=0.
- Test 3, back-pressure:
  - in_valid toggles 1/0 each cycle; out_ready is low for 3 cycles at element 4.
  - Required: identical results to Test 1; out_data stable while stalled; no duplicated or dropped element.
- Test 4, maximum values: A=15, B=15.
  - Required: every output 675; no truncation at ACC_WIDTH=13.
- Test 5, reset mid-operation:
  - Assert rst after 5 A-beats, then stream a full Test 2 set.
  - Required: outputs all 12; in_ready=0 during reset; op_count shows only 1 completion.
- Test 6, with TLUT_OP_COUNT_EN: run 3 back-to-back operations.
  - Required: op_count=3.
  - In a build without the macro, op_count stays 0.
